// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : countdown_timer_ctrl
// Purpose  : Prescaled countdown timer. Loads a start value, decrements it
//            once every TICK_DIV clocks and emits a one-cycle done pulse on
//            expiry. Supports pause/resume, abort, restart-on-start and a
//            low-count warning flag. count_o feeds the BCD / seven-segment
//            display path; done_o returns to the calculator control FSM.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W      width of load_val_i / count_o (>= 2)
//   TICK_DIV   clk cycles per count decrement (>= 2)
//   WARN_LEVEL warn_o threshold (CNT_W bits)
// Ports
//   clk         in   1      clock
//   rst_n       in   1      asynchronous active-low reset
//   load_val_i  in   CNT_W  start value, sampled on an accepted start
//   start_i     in   1      load and run (restarts when already counting)
//   pause_i     in   1      freeze the countdown (RUN)
//   resume_i    in   1      continue the countdown (PAUSE)
//   abort_i     in   1      cancel, back to IDLE without done
//   count_o     out  CNT_W  remaining count
//   busy_o      out  1      RUN or PAUSE
//   paused_o    out  1      PAUSE
//   tick_out_o  out  1      high in the cycle a decrement is committed
//   warn_o      out  1      busy and 0 < count <= WARN_LEVEL
//   done_o      out  1      one-cycle expiry pulse
// ============================================================================
module countdown_timer_ctrl #(
  parameter int               CNT_W      = 16,
  parameter int               TICK_DIV   = 100_000_000,
  parameter logic [CNT_W-1:0] WARN_LEVEL = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             resume_i,
  input  logic             abort_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             paused_o,
  output logic             tick_out_o,
  output logic             warn_o,
  output logic             done_o
);

  // Prescaler counts 0 .. TICK_DIV-1; guard keeps the width legal even if
  // the parameter is misconfigured below its minimum.
  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q,   pre_d;

  logic             w_load_zero;
  logic             w_advance;
  logic             w_tick;

  assign w_load_zero = (load_val_i == '0);

  // --------------------------------------------------------------------------
  // State, count and prescaler registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: abort > start > pause/resume > tick.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pre_d     = pre_q;
    w_advance = 1'b0;
    w_tick    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort/pause/resume are meaningless while idle
        if (start_i) begin
          pre_d = '0;
          if (w_load_zero) begin
            count_d = '0;
            state_d = S_DONE;
          end else begin
            count_d = load_val_i;
            state_d = S_RUN;
          end
        end
      end

      S_RUN, S_PAUSE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (start_i) begin
          // Restart from the new value with a fresh tick period
          pre_d = '0;
          if (w_load_zero) begin
            count_d = '0;
            state_d = S_DONE;
          end else begin
            count_d = load_val_i;
            state_d = S_RUN;
          end
        end else begin
          if (state_q == S_RUN) begin
            if (pause_i) begin
              state_d = S_PAUSE;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            // The pause-request cycle in RUN does not advance, while the
            // resume cycle does: the number of advancing cycles therefore
            // stays N*TICK_DIV and a pause of P cycles shifts done by P.
            if (resume_i && !pause_i) begin
              state_d   = S_RUN;
              w_advance = 1'b1;
            end
          end

          if (w_advance) begin
            if (pre_q == PRE_LAST) begin
              pre_d = '0;
              // count is always >= 1 while counting; the guard makes
              // underflow structurally impossible.
              if (count_q != '0) begin
                w_tick  = 1'b1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                  state_d = S_DONE;
                end
              end
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
          end
        end
      end

      S_DONE: begin
        // Single-cycle state; any start here is dropped on purpose
        state_d = S_IDLE;
        count_d = '0;
        pre_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        pre_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (no extra pipeline stages)
  // --------------------------------------------------------------------------
  assign count_o    = count_q;
  assign busy_o     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign paused_o   = (state_q == S_PAUSE);
  assign done_o     = (state_q == S_DONE);
  assign tick_out_o = w_tick;
  assign warn_o     = busy_o && (count_q != '0) && (count_q <= WARN_LEVEL);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_countdown_timer_ctrl
// Purpose  : Directed self-checking bench for countdown_timer_ctrl with
//            CNT_W=8, TICK_DIV=4, WARN_LEVEL=2. Cycle index j counts edges
//            after the edge E0 that accepts start; outputs are sampled 2 ns
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] load_val = '0;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic       resume = 1'b0;
  logic       abort  = 1'b0;
  logic [7:0] count;
  logic       busy, paused, tick_out, warn, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .CNT_W     (8),
    .TICK_DIV  (4),
    .WARN_LEVEL(8'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_val_i(load_val),
    .start_i   (start),
    .pause_i   (pause),
    .resume_i  (resume),
    .abort_i   (abort),
    .count_o   (count),
    .busy_o    (busy),
    .paused_o  (paused),
    .tick_out_o(tick_out),
    .warn_o    (warn),
    .done_o    (done)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({count, busy, paused, tick_out, warn, done} !== 13'd0) begin
      bad++;
      $display("FAIL reset_async outs=%b want=0", {count, busy, paused, tick_out, warn, done});
    end
    step(2);
    total++;
    if ({count, busy, paused, tick_out, warn, done} !== 13'd0) begin
      bad++;
      $display("FAIL reset_held outs=%b want=0", {count, busy, paused, tick_out, warn, done});
    end
    rst_n = 1'b1;
    step(2);
    total++;
    if ({count, busy, done} !== 10'd0) begin
      bad++;
      $display("FAIL reset_idle count=%0d busy=%b done=%b want 0", count, busy, done);
    end
  endtask

  task automatic test_basic;
    int  exp_cnt  [14] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
    bit  exp_tick [14] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    bit  exp_warn [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit  exp_busy [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit  exp_done [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    load_val = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      total++;
      if (count !== 8'(exp_cnt[j])) begin
        bad++; $display("FAIL basic_count j=%0d got=%0d want=%0d", j, count, exp_cnt[j]);
      end
      total++;
      if (tick_out !== exp_tick[j]) begin
        bad++; $display("FAIL basic_tick j=%0d got=%b want=%b", j, tick_out, exp_tick[j]);
      end
      total++;
      if (warn !== exp_warn[j]) begin
        bad++; $display("FAIL basic_warn j=%0d got=%b want=%b", j, warn, exp_warn[j]);
      end
      total++;
      if (busy !== exp_busy[j]) begin
        bad++; $display("FAIL basic_busy j=%0d got=%b want=%b", j, busy, exp_busy[j]);
      end
      total++;
      if (done !== exp_done[j]) begin
        bad++; $display("FAIL basic_done j=%0d got=%b want=%b", j, done, exp_done[j]);
      end
      step(1);
    end
  endtask

  // load 2, pause sampled at E0+2, resume sampled at E0+7: paused for 5
  // cycles, done moves from j=8 to j=13.
  task automatic test_pause;
    logic [7:0] exp_c;
    load_val = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    for (int j = 2; j <= 14; j++) begin
      resume = 1'b0;
      exp_c = (j <= 8) ? 8'd2 : (j <= 12) ? 8'd1 : 8'd0;
      total++;
      if (paused !== (j >= 2 && j <= 6)) begin
        bad++; $display("FAIL pause_paused j=%0d got=%b want=%b", j, paused, (j >= 2 && j <= 6));
      end
      total++;
      if (count !== exp_c) begin
        bad++; $display("FAIL pause_count j=%0d got=%0d want=%0d", j, count, exp_c);
      end
      total++;
      if (done !== (j == 13)) begin
        bad++; $display("FAIL pause_done j=%0d got=%b want=%b", j, done, (j == 13));
      end
      if (j == 6) resume = 1'b1;
      step(1);
    end
  endtask

  task automatic test_abort;
    int pulses = 0;
    load_val = 8'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    total++;
    if (count !== 8'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre count=%0d busy=%b want 4/1", count, busy);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_post count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) pulses++;
      step(1);
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL abort_no_done pulses=%0d want=0", pulses);
    end
  endtask

  // load 4 at E0, restart with 9 at E0+5: done at j=41.
  task automatic test_restart;
    load_val = 8'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    load_val = 8'd9; start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (count !== 8'd9 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_load count=%0d busy=%b want 9/1", count, busy);
    end
    for (int j = 5; j <= 42; j++) begin
      if (j == 7) begin
        total++;
        if (tick_out !== 1'b0) begin
          bad++; $display("FAIL restart_old_tick got=%b want=0", tick_out);
        end
      end
      if (j == 8) begin
        total++;
        if (tick_out !== 1'b1) begin
          bad++; $display("FAIL restart_new_tick got=%b want=1", tick_out);
        end
      end
      if (j == 9) begin
        total++;
        if (count !== 8'd8) begin
          bad++; $display("FAIL restart_dec got=%0d want=8", count);
        end
      end
      total++;
      if (done !== (j == 41)) begin
        bad++; $display("FAIL restart_done j=%0d got=%b want=%b", j, done, (j == 41));
      end
      step(1);
    end
  endtask

  task automatic test_zero_load;
    load_val = 8'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      bad++; $display("FAIL zero_done done=%b busy=%b count=%0d want 1/0/0", done, busy, count);
    end
    step(1);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_after done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_abort_start;
    load_val = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    abort = 1'b1; start = 1'b1; load_val = 8'd7;
    step(1);
    abort = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_start busy=%b count=%0d done=%b want 0/0/0", busy, count, done);
    end
    step(1);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_start_idle busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_pause_on_tick;
    load_val = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    total++;
    if (tick_out !== 1'b1) begin
      bad++; $display("FAIL tickpause_pre got=%b want=1", tick_out);
    end
    pause = 1'b1;
    #1;
    total++;
    if (tick_out !== 1'b0) begin
      bad++; $display("FAIL tickpause_suppress got=%b want=0", tick_out);
    end
    step(1);
    pause = 1'b0;
    total++;
    if (paused !== 1'b1 || count !== 8'd3) begin
      bad++; $display("FAIL tickpause_hold paused=%b count=%0d want 1/3", paused, count);
    end
    resume = 1'b1;
    #1;
    total++;
    if (tick_out !== 1'b1) begin
      bad++; $display("FAIL tickpause_resume_tick got=%b want=1", tick_out);
    end
    step(1);
    resume = 1'b0;
    total++;
    if (count !== 8'd2 || paused !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL tickpause_after count=%0d paused=%b busy=%b want 2/0/1", count, paused, busy);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int activity = 0;
    load_val = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    total++;
    if (busy !== 1'b1 || tick_out !== 1'b1) begin
      bad++; $display("FAIL midrst_pre busy=%b tick=%b want 1/1", busy, tick_out);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({count, busy, paused, tick_out, warn, done} !== 13'd0) begin
      bad++; $display("FAIL midrst_async outs=%b want=0", {count, busy, paused, tick_out, warn, done});
    end
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0 || tick_out !== 1'b0) activity++;
      step(1);
    end
    total++;
    if (activity != 0) begin
      bad++; $display("FAIL midrst_quiet active_cycles=%0d want=0", activity);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    step(2);
    test_pause();
    step(2);
    test_abort();
    step(2);
    test_restart();
    step(2);
    test_zero_load();
    step(2);
    test_abort_start();
    step(2);
    test_pause_on_tick();
    step(2);
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
